// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle MIPS core: fetch state encoding,
// decoder opcode constants and address-width helpers.
package core_pkg;

    localparam int ADDR_W = 32;

    localparam logic [5:0] OP_RTYPE     = 6'b000000;
    localparam logic [5:0] OP_J         = 6'b000010;
    localparam logic [5:0] OP_JAL       = 6'b000011;
    localparam logic [5:0] FUNC_SYSCALL = 6'b001100;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_HALT = 2'd3
    } fetch_state_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

    function automatic logic is_syscall(input logic [31:0] word);
        return (word[31:26] == OP_RTYPE) && (word[5:0] == FUNC_SYSCALL);
    endfunction

    function automatic logic is_jump_op(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_unit_if;
    import core_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid;
    logic [31:0]       imem_data;

    modport master (output imem_req, output imem_addr, input imem_valid, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_data);

endinterface

// File: rtl/next_pc_calc.sv
// Next-PC selection: jump target, taken-branch target or sequential PC,
// with jump taking priority over a simultaneous branch.
module next_pc_calc
    import core_pkg::*;
(
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [31:0]       inst,
    input  logic              jump,
    input  logic              branch,
    input  logic              branch_taken,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] jump_target_s;
    logic [ADDR_W-1:0] branch_offset_s;
    logic [ADDR_W-1:0] branch_target_s;
    logic              unused_opcode_s;

    assign jump_target_s   = {pc_plus4[31:28], inst[25:0], 2'b00};
    assign branch_offset_s = {{14{inst[15]}}, inst[15:0], 2'b00};
    // Modulo-2^32 add: negative offsets and overflow wrap naturally.
    assign branch_target_s = pc_plus4 + branch_offset_s;
    assign unused_opcode_s = ^inst[31:26];

    // Priority select of the next fetch address.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target_s;
        end else if (branch && branch_taken) begin
            next_pc = branch_target_s;
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over the imem bus, holds the
// instruction register for the decoder and freezes the core on halt.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      imem,
    output logic [31:0]       inst,
    output logic [5:0]        opcode,
    output logic [5:0]        func,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              jump,
    input  logic              branch,
    input  logic              branch_taken,
    input  logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              halted_o,
    output logic [CNT_W-1:0]  inst_count
);

    fetch_state_t      state_r;
    fetch_state_t      state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [ADDR_W-1:0] pc_plus4_s;
    logic [ADDR_W-1:0] next_pc_s;
    logic [31:0]       inst_r;
    logic [31:0]       inst_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              drop_pending_r;
    logic              drop_nxt_s;
    logic              imem_req_r;
    logic              inst_valid_r;
    logic              halted_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end else begin
            return c + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign pc_plus4_s = pc_r + 32'd4;

    next_pc_calc u_next_pc_calc (
        .pc_plus4     (pc_plus4_s),
        .inst         (inst_r),
        .jump         (jump),
        .branch       (branch),
        .branch_taken (branch_taken),
        .next_pc      (next_pc_s)
    );

    // Next-state and next-datapath logic of the fetch sequencer.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        inst_nxt_s  = inst_r;
        cnt_nxt_s   = cnt_r;
        drop_nxt_s  = drop_pending_r;
        case (state_r)
            // Outputs are registered, so the request pulse appears one cycle
            // after entry when S_REQ is entered out of reset.
            S_REQ: begin
                if (imem_req_r) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem.imem_valid) begin
                    if (drop_pending_r) begin
                        drop_nxt_s  = 1'b0;
                        state_nxt_s = S_REQ;
                    end else begin
                        inst_nxt_s  = imem.imem_data;
                        state_nxt_s = S_EXEC;
                    end
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_EXEC: begin
                if (inst_ready) begin
                    cnt_nxt_s = sat_inc(cnt_r);
                    if (halted) begin
                        state_nxt_s = S_HALT;
                    end else begin
                        pc_nxt_s    = next_pc_s;
                        state_nxt_s = S_REQ;
                    end
                end else begin
                    state_nxt_s = S_EXEC;
                end
            end
            S_HALT: begin
                state_nxt_s = S_HALT;
            end
            default: begin
                state_nxt_s = S_REQ;
            end
        endcase
    end

    // State, datapath and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= S_REQ;
            pc_r           <= word_align(RESET_PC);
            inst_r         <= 32'h0000_0000;
            cnt_r          <= {CNT_W{1'b0}};
            // A reset mid-fetch leaves one response in flight that must be discarded.
            drop_pending_r <= (state_r == S_WAIT);
            imem_req_r     <= 1'b0;
            inst_valid_r   <= 1'b0;
            halted_r       <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            pc_r           <= pc_nxt_s;
            inst_r         <= inst_nxt_s;
            cnt_r          <= cnt_nxt_s;
            drop_pending_r <= drop_nxt_s;
            imem_req_r     <= (state_nxt_s == S_REQ);
            inst_valid_r   <= (state_nxt_s == S_EXEC);
            halted_r       <= (state_nxt_s == S_HALT);
        end
    end

    assign imem.imem_req  = imem_req_r;
    assign imem.imem_addr = pc_r;
    assign inst           = inst_r;
    assign opcode         = inst_r[31:26];
    assign func           = inst_r[5:0];
    assign inst_valid     = inst_valid_r;
    assign pc             = pc_r;
    assign pc_plus4       = pc_plus4_s;
    assign halted_o       = halted_r;
    assign inst_count     = cnt_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed and randomized instruction
// streams checked against an architectural next-PC / retire-count model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic        sel = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        inst_ready = 1'b0;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic        halted = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [31:0] cnt_max;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_unit_if if_a ();
    fetch_unit_if if_b ();
    assign if_a.imem_valid = imem_valid;
    assign if_a.imem_data  = imem_data;
    assign if_b.imem_valid = imem_valid;
    assign if_b.imem_data  = imem_data;

    logic [31:0] inst_a, pc_a, pc4_a, cnt_a, inst_b, pc_b, pc4_b;
    logic [5:0]  op_a, fn_a, op_b, fn_b;
    logic        iv_a, ho_a, iv_b, ho_b;
    logic [1:0]  cnt_b;

    fetch_unit u_dut (
        .clk(clk), .rst(rst_a), .imem(if_a.master),
        .inst(inst_a), .opcode(op_a), .func(fn_a), .inst_valid(iv_a),
        .inst_ready(inst_ready), .jump(jump), .branch(branch),
        .branch_taken(branch_taken), .halted(halted),
        .pc(pc_a), .pc_plus4(pc4_a), .halted_o(ho_a), .inst_count(cnt_a)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFF), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst_b), .imem(if_b.master),
        .inst(inst_b), .opcode(op_b), .func(fn_b), .inst_valid(iv_b),
        .inst_ready(inst_ready), .jump(jump), .branch(branch),
        .branch_taken(branch_taken), .halted(halted),
        .pc(pc_b), .pc_plus4(pc4_b), .halted_o(ho_b), .inst_count(cnt_b)
    );

    // Observation mux: sel picks which DUT the directed steps talk to.
    logic        m_req, m_iv, m_ho;
    logic [31:0] m_addr, m_inst, m_pc, m_pc4, m_cnt;
    logic [5:0]  m_op, m_fn;
    assign m_req  = sel ? if_b.imem_req  : if_a.imem_req;
    assign m_addr = sel ? if_b.imem_addr : if_a.imem_addr;
    assign m_iv   = sel ? iv_b  : iv_a;
    assign m_ho   = sel ? ho_b  : ho_a;
    assign m_inst = sel ? inst_b : inst_a;
    assign m_pc   = sel ? pc_b  : pc_a;
    assign m_pc4  = sel ? pc4_b : pc4_a;
    assign m_op   = sel ? op_b  : op_a;
    assign m_fn   = sel ? fn_b  : fn_a;
    assign m_cnt  = sel ? {30'b0, cnt_b} : cnt_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rule written with plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic j, input logic b, input logic bt);
        logic [31:0] seq;
        int          off;
        seq = p + 32'd4;
        off = int'($signed(w[15:0]));
        if (j) return (seq & 32'hF000_0000) | ({6'b0, w[25:0]} << 2);
        if (b && bt) return seq + 32'(off * 4);
        return seq;
    endfunction

    task automatic do_reset(input logic [31:0] rpc);
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        tick();
        check("rst_pc", m_pc, rpc);
        check("rst_inst", m_inst, 32'h0);
        check("rst_cnt", m_cnt, 32'h0);
        check("rst_req", 32'(m_req), 32'h0);
        check("rst_inst_valid", 32'(m_iv), 32'h0);
        check("rst_halted_o", 32'(m_ho), 32'h0);
        check("rst_opfn", {20'h0, m_op, m_fn}, 32'h0);
        rst_a = sel;
        rst_b = ~sel;
        exp_pc  = rpc;
        exp_cnt = 32'h0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic run_inst(input logic [31:0] w, input logic j, input logic b, input logic bt,
                            input logic h, input int lat, input int rdly, input logic spur);
        bit ok;
        int req_cyc;
        wait_req(ok);
        check("req_seen", 32'(ok), 32'h1);
        if (!ok) return;
        check("imem_addr", m_addr, exp_pc);
        req_cyc = cyc;
        tick();
        check("req_pulse", 32'(m_req), 32'h0);
        repeat (lat - 1) tick();
        imem_valid = 1'b1;
        imem_data  = w;
        tick();
        imem_valid = 1'b0;
        imem_data  = $urandom();
        check("inst_valid", 32'(m_iv), 32'h1);
        if (lat == 1) check("fetch_latency", 32'(cyc - req_cyc), 32'd2);
        check("inst", m_inst, w);
        check("opcode", 32'(m_op), 32'(w[31:26]));
        check("func", 32'(m_fn), 32'(w[5:0]));
        check("pc", m_pc, exp_pc);
        check("pc_plus4", m_pc4, exp_pc + 32'd4);
        for (int k = 0; k < rdly; k++) begin
            imem_valid = spur;
            imem_data  = ~w;
            tick();
            imem_valid = 1'b0;
            check("inst_hold", m_inst, w);
            check("pc_hold", m_pc, exp_pc);
        end
        jump = j; branch = b; branch_taken = bt; halted = h; inst_ready = 1'b1;
        tick();
        jump = 1'b0; branch = 1'b0; branch_taken = 1'b0; halted = 1'b0; inst_ready = 1'b0;
        if (exp_cnt != cnt_max) exp_cnt = exp_cnt + 32'd1;
        if (!h) exp_pc = ref_next(exp_pc, w, j, b, bt);
        check("inst_count", m_cnt, exp_cnt);
        check("inst_valid_drop", 32'(m_iv), 32'h0);
        check("halted_o", 32'(m_ho), 32'(h));
        check("pc_after", m_pc, exp_pc);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] r;
        bit          ok;
        int          reqs;

        cnt_max = 32'hFFFF_FFFF;
        sel = 1'b0;
        tick();
        do_reset(32'h0000_0000);

        // Three sequential instructions at 0, 4, 8.
        for (int n = 0; n < 3; n++) run_inst(32'h012A_4020, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
        check("count_three", m_cnt, 32'd3);

        // Jump to 0x100, then jump-to-self alone and with a taken branch.
        run_inst(32'h0800_0040, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
        check("jump_to_100", m_pc, 32'h0000_0100);
        run_inst(32'h0800_0040, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1'b1);
        check("jump_self", m_pc, 32'h0000_0100);
        run_inst(32'h0800_0040, 1'b1, 1'b1, 1'b1, 1'b0, 2, 0, 1'b0);
        check("jump_over_branch", m_pc, 32'h0000_0100);

        // Backward BEQ at 0x20, taken and not taken.
        run_inst(32'h0800_0008, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
        run_inst(32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 1'b0);
        check("beq_taken", m_pc, 32'h0000_001C);
        run_inst(32'h0800_0008, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
        run_inst(32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0);
        check("beq_not_taken", m_pc, 32'h0000_0024);

        // Randomized instruction stream with varying latency and stall.
        for (int n = 0; n < 30; n++) begin
            w = $urandom();
            r = $urandom();
            run_inst(w, r[1:0] == 2'b00, r[2], r[3], 1'b0,
                     $urandom_range(1, 3), $urandom_range(0, 2), r[4]);
        end

        // Halt: frozen, no requests, stray responses ignored.
        run_inst(32'h0000_000C, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0);
        reqs = 0;
        for (int k = 0; k < 20; k++) begin
            imem_valid = k[0];
            tick();
            if (m_req) reqs++;
        end
        imem_valid = 1'b0;
        check("halt_no_req", 32'(reqs), 32'd0);
        check("halt_sticky", 32'(m_ho), 32'h1);
        check("halt_count_stable", m_cnt, exp_cnt);

        do_reset(32'h0000_0000);
        run_inst(32'h012A_4020, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);

        // Reset while waiting; stale response must be dropped and refetched.
        wait_req(ok);
        check("req_before_rst", 32'(ok), 32'h1);
        tick();
        do_reset(32'h0000_0000);
        tick();
        check("req_after_rst", 32'(m_req), 32'h1);
        tick();
        imem_valid = 1'b1;
        imem_data  = 32'hDEAD_BEEF;
        tick();
        imem_valid = 1'b0;
        check("stale_not_exec", 32'(m_iv), 32'h0);
        check("stale_discarded", m_inst, 32'h0);
        check("reissue_req", 32'(m_req), 32'h1);
        run_inst(32'h2108_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);

        // Second instance: top-of-memory reset PC and saturating counter.
        sel = 1'b1;
        cnt_max = 32'd3;
        do_reset(32'hFFFF_FFFC);
        run_inst(32'h012A_4020, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
        check("pc_wrap", m_pc, 32'h0000_0000);
        for (int n = 0; n < 4; n++) run_inst(32'h012A_4020, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
        check("count_saturated", m_cnt, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
